// File: rtl/fifo_pkg.sv
// Shared parameter helpers for the width-converting FIFO: legality check,
// storage depth and occupancy-counter width.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_RATIO      = 2;

    // Narrow entries held by a FIFO with the given address width.
    function automatic int fifo_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

    // The count must reach DEPTH itself, so it needs one bit more than a pointer.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // RATIO must be a power of two between 2 and half the depth.
    function automatic bit ratio_legal(input int ratio, input int addr_width);
        return (ratio >= 2) &&
               ((ratio & (ratio - 1)) == 0) &&
               (ratio <= fifo_depth(addr_width) / 2);
    endfunction

endpackage

// File: rtl/asym_reg_file.sv
// Storage array: RATIO consecutive narrow entries written per clock from a
// base index, one narrow entry read asynchronously. Contents are not reset.
module asym_reg_file
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RATIO      = DEFAULT_RATIO
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [ADDR_WIDTH-1:0]         i_wr_base,
    input  logic [RATIO*DATA_WIDTH-1:0]   i_wr_data,
    input  logic [ADDR_WIDTH-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0]         o_rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Index arithmetic is ADDR_WIDTH bits wide, so base+k wraps modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < RATIO; k++) begin
                r_mem[i_wr_base + ADDR_WIDTH'(k)] <= i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/wide_wr_fifo.sv
// Width-converting FIFO: RATIO narrow entries in per write, one out per read,
// with show-ahead output, occupancy count and sticky overflow/underflow flags.
module wide_wr_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RATIO      = DEFAULT_RATIO
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  wr,
    input  logic [RATIO*DATA_WIDTH-1:0]           w_data,
    input  logic                                  rd,
    output logic [DATA_WIDTH-1:0]                 r_data,
    output logic                                  empty,
    output logic                                  full,
    output logic [count_width(ADDR_WIDTH)-1:0]    count,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    if (!ratio_legal(RATIO, ADDR_WIDTH)) begin : g_bad_ratio
        $error("wide_wr_fifo: RATIO must be a power of two in [2, DEPTH/2]");
    end

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [DATA_WIDTH-1:0] w_head;

    // Full means fewer than RATIO free slots, i.e. count > DEPTH - RATIO.
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count > CW'(DEPTH - RATIO));
    assign w_wr_accept = wr && !w_full;
    assign w_rd_accept = rd && !w_empty;

    asym_reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RATIO      (RATIO)
    ) u_reg_file (
        .i_clk      (clk),
        .i_we       (w_wr_accept),
        .i_wr_base  (r_wptr),
        .i_wr_data  (w_data),
        .i_rd_addr  (r_rptr),
        .o_rd_data  (w_head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(RATIO);
            end
            if (w_rd_accept) begin
                r_rptr <= r_rptr + ADDR_WIDTH'(1);
            end
            r_count <= r_count
                     + (w_wr_accept ? CW'(RATIO) : CW'(0))
                     - (w_rd_accept ? CW'(1) : CW'(0));
            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign r_data    = w_empty ? '0 : w_head;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_wide_wr_fifo.sv
// Self-checking bench for wide_wr_fifo (8-bit entries, depth 16, ratio 2)
// against a queue-based reference model.
module tb_wide_wr_fifo;

    logic        clk;
    logic        reset_n;
    logic        wr;
    logic [15:0] w_data;
    logic        rd;
    logic [7:0]  r_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int testsRun;
    int testsFailed;

    logic [7:0] mq[$];
    bit         mOvf;
    bit         mUnf;

    wide_wr_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .RATIO      (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr        (wr),
        .w_data    (w_data),
        .rd        (rd),
        .r_data    (r_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "/count"}, 32'(count), 32'(mq.size()));
        checkOutput({tag, "/empty"}, 32'(empty), 32'(mq.size() == 0));
        checkOutput({tag, "/full"}, 32'(full), 32'((16 - mq.size()) < 2));
        checkOutput({tag, "/r_data"}, 32'(r_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        checkOutput({tag, "/overflow"}, 32'(overflow), 32'(mOvf));
        checkOutput({tag, "/underflow"}, 32'(underflow), 32'(mUnf));
    endtask

    task automatic modelReset();
        mq.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    // Drive one cycle's requests; the model decides acceptance on pre-edge state.
    task automatic applyStimulus(input bit doWr, input bit doRd, input logic [15:0] data);
        bit preFull;
        bit preEmpty;
        wr       = doWr;
        rd       = doRd;
        w_data   = data;
        preFull  = (16 - mq.size()) < 2;
        preEmpty = (mq.size() == 0);
        @(posedge clk);
        if (doWr && preFull)  mOvf = 1'b1;
        if (doRd && preEmpty) mUnf = 1'b1;
        if (doRd && !preEmpty) void'(mq.pop_front());
        if (doWr && !preFull) begin
            mq.push_back(data[7:0]);
            mq.push_back(data[15:8]);
        end
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        wr          = 1'b0;
        rd          = 1'b0;
        w_data      = '0;
        reset_n     = 1'b0;
        modelReset();
        #2;
        checkModel("reset");
        #5;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Ordering
        applyStimulus(1, 0, 16'hBBAA);
        checkOutput("order/aa", 32'(r_data), 32'hAA);
        checkOutput("order/count2", 32'(count), 32'd2);
        applyStimulus(0, 1, 16'h0);
        checkOutput("order/bb", 32'(r_data), 32'hBB);
        applyStimulus(0, 1, 16'h0);
        checkOutput("order/empty", 32'(empty), 32'd1);
        checkOutput("order/zero", 32'(r_data), 32'd0);

        // Fill and overflow
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 16'(16'h1000 + i * 16'h0101));
        end
        checkOutput("fill/count16", 32'(count), 32'd16);
        checkOutput("fill/full", 32'(full), 32'd1);
        applyStimulus(1, 0, 16'h1234);
        checkOutput("ovf/flag", 32'(overflow), 32'd1);
        checkOutput("ovf/count", 32'(count), 32'd16);
        checkModel("ovf");

        // Full threshold
        applyStimulus(0, 1, 16'h0);
        checkOutput("thr/count15", 32'(count), 32'd15);
        checkOutput("thr/full15", 32'(full), 32'd1);
        applyStimulus(0, 1, 16'h0);
        checkOutput("thr/count14", 32'(count), 32'd14);
        checkOutput("thr/full14", 32'(full), 32'd0);
        checkModel("thr");

        // Simultaneous read and write at count 14
        applyStimulus(1, 1, 16'hD1C0);
        checkOutput("sim/count15", 32'(count), 32'd15);
        checkModel("sim");

        // Streaming across the wrap point
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1, 16'($urandom));
            checkModel("stream");
        end
        while (mq.size() != 0 && testsRun < 5000) begin
            applyStimulus(0, 1, 16'h0);
            checkModel("drain");
        end

        // Underflow, then reset in the middle of activity
        applyStimulus(0, 1, 16'h0);
        checkOutput("unf/flag", 32'(underflow), 32'd1);
        checkOutput("unf/count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 16'(16'hA0A0 + i));
        end
        checkOutput("rst/count6", 32'(count), 32'd6);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst/count0", 32'(count), 32'd0);
        checkOutput("rst/empty", 32'(empty), 32'd1);
        checkOutput("rst/unf", 32'(underflow), 32'd0);
        checkModel("rst");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1, 0, 16'h5566);
        checkOutput("post/66", 32'(r_data), 32'h66);
        applyStimulus(0, 1, 16'h0);
        checkOutput("post/55", 32'(r_data), 32'h55);
        applyStimulus(0, 1, 16'h0);
        checkModel("post");

        // Randomised traffic with an occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset_n = 1'b0;
                modelReset();
                #1;
                checkModel("rand/reset");
                @(negedge clk);
                reset_n = 1'b1;
            end
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 16'($urandom));
            checkModel("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wide_wr_fifo.md
# wide_wr_fifo

Width-converting FIFO. Each write accepts RATIO narrow entries packed in one wide word, and each read returns one narrow entry. It generalises the dual-address, double-width-write register file to any power-of-two ratio and adds pointer control, occupancy and status flags. It sits between a wide producer and a DATA_WIDTH-wide consumer, for example a 16-bit input feeding an 8-bit output stage.

## Interface
- DATA_WIDTH, default 8: width of one narrow entry and of r_data.
- ADDR_WIDTH, default 4: the FIFO holds 2**ADDR_WIDTH narrow entries.
- RATIO, default 2: narrow entries per write. Must be a power of two, and 2 ≤ RATIO ≤ 2**(ADDR_WIDTH-1).
- clk, input, 1: the single clock. Everything is updated on the posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- wr, input, 1: write request.
- w_data, input, RATIO*DATA_WIDTH: write word. Lane k is bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- rd, input, 1: read request. It pops the entry currently shown on r_data.
- r_data, output, DATA_WIDTH: head entry (show-ahead).
- empty, output, 1: count == 0.
- full, output, 1: free space is less than RATIO, so a write cannot be accepted.
- count, output, ADDR_WIDTH+1: number of narrow entries stored.
- overflow, output, 1: sticky. Set when wr is asserted while full.
- underflow, output, 1: sticky. Set when rd is asserted while empty.

## Operation
- Storage is 2**ADDR_WIDTH narrow entries. Storage contents are not reset.
- An accepted write stores lane k at index (wptr+k) mod 2**ADDR_WIDTH, for k = 0..RATIO-1, then advances wptr by RATIO. Lane 0 (the LSBs) is read first.
- wptr is always a multiple of RATIO, so a write never straddles the wrap point in a misaligned way. The modular arithmetic still handles the wrap explicitly.
- An accepted read advances rptr by 1 mod 2**ADDR_WIDTH.
- Accept rules are evaluated on the state before the edge:
  - Write is accepted when wr=1 and full=0.
  - Read is accepted when rd=1 and empty=0.
  - A rejected request does not change storage, pointers or count.
- Count update per cycle: count_next = count + (RATIO if the write is accepted) − (1 if the read is accepted).
  - Both can happen in the same cycle. full and empty are not re-evaluated mid-cycle.
  - A read at full and a write at empty are never bypassed: a write into an empty FIFO is not readable in the same cycle.
- r_data = storage[rptr] when empty=0, and 0 when empty=1.
- overflow and underflow stay set until reset_n is asserted. They are not cleared by later successful operations.
- Reset (asserted at any time, including mid-burst):
  - wptr, rptr and count clear to 0.
  - empty=1, full=0, overflow=0, underflow=0, r_data=0.
  - In-flight data is discarded.

## Timing
- Writes, reads, count and the sticky flags update on the posedge of clk.
- empty, full and r_data are combinational from the registered pointers and count, with no extra pipeline stage.
- Write-to-read latency is 1 cycle. Data written at edge N is on r_data and poppable from cycle N+1.
- Read-to-next-data is 0 cycles. After the edge that pops the head, r_data shows the next entry.
- Reset is asynchronous assert. Its release is sampled on the posedge. The first request is accepted on the first edge with reset_n=1.
- Throughput: one wide write and one narrow read per cycle. Because input bandwidth is RATIO times the output bandwidth, sustained writing saturates the FIFO and full throttles the producer.

## Structure
- Package fifo_pkg holds:
  - the parameter-legality check (RATIO a power of two, RATIO ≤ depth/2), raised as an elaboration error;
  - a localparam DEPTH = 2**ADDR_WIDTH;
  - the count-width computation.
- Sub-module asym_reg_file is the storage array:
  - synchronous RATIO-lane write at consecutive indices starting at a base address, enabled by a write enable;
  - asynchronous single-entry read.
- The top level holds the pointers, count, flags and accept logic.

## Test plan
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, RATIO=2.
- Reset: drive reset_n=0 mid-cycle → empty=1, full=0, count=0, r_data=0, overflow=0, underflow=0, all without waiting for a clock edge.
- Ordering: write 16'hBBAA → next cycle r_data=AA and count=2. rd → r_data=BB. rd → empty=1 and r_data=0.
- Fill and overflow: 8 consecutive writes → count=16 and full=1. A 9th write of 16'h1234 is ignored, overflow=1, and count stays 16.
- Full threshold: from count=16, one rd → count=15 and full stays 1. A second rd → count=14 and full=0.
- Simultaneous and wrap: at count=14, rd and wr on the same edge → count=15, with the popped value and ordering correct. Stream 40 writes with back-to-back reads past index 15→0 → output equals the input lanes in lane-0-first order.
- Underflow and reset mid-operation: rd while empty → underflow=1 and count=0. Fill to count=6, assert reset_n=0 → count=0, empty=1, underflow=0. After release, a write of 16'h5566 reads out 66 then 55.
